// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for a multi-ported register file.
// Each cycle the requesters are scanned round-robin starting at rrPtr. Every
// valid requester is granted until WRITE_NUM grants are issued, skipping any
// requester whose destination matches a register already granted in the same
// scan. The k-th grant drives write port k one cycle later. Writes to register
// 0 are accepted but never strobed.
//
// Ports:
//   clk          clock, rising edge
//   rstN         asynchronous active-low reset
//   stall        blocks all grants this cycle
//   reqValid     per-requester write-back valid
//   reqAddr      per-requester destination register, [AW*i +: AW]
//   reqData      per-requester write data, [DATA_WIDTH*i +: DATA_WIDTH]
//   reqReady     per-requester grant (combinational)
//   writeEnable  registered per-port write strobe
//   writeAddr    registered per-port register address, [AW*p +: AW]
//   dataInputs   registered per-port write data, [DATA_WIDTH*p +: DATA_WIDTH]
//   rrPtr        current round-robin start index
module regfile_wb_arbiter #(
  parameter int unsigned REQ_NUM    = 8,
  parameter int unsigned WRITE_NUM  = 4,
  parameter int unsigned REG_NUM    = 32,
  parameter int unsigned DATA_WIDTH = 32,
  localparam int unsigned AW        = $clog2(REG_NUM),
  localparam int unsigned RW        = $clog2(REQ_NUM)
) (
  input  logic                            clk,
  input  logic                            rstN,
  input  logic                            stall,
  input  logic [REQ_NUM-1:0]              reqValid,
  input  logic [AW*REQ_NUM-1:0]           reqAddr,
  input  logic [DATA_WIDTH*REQ_NUM-1:0]   reqData,
  output logic [REQ_NUM-1:0]              reqReady,
  output logic [WRITE_NUM-1:0]            writeEnable,
  output logic [AW*WRITE_NUM-1:0]         writeAddr,
  output logic [DATA_WIDTH*WRITE_NUM-1:0] dataInputs,
  output logic [RW-1:0]                   rrPtr
);

  logic [AW-1:0]         req_addr [REQ_NUM];
  logic [DATA_WIDTH-1:0] req_data [REQ_NUM];

  logic [REQ_NUM-1:0]    grant_c;
  logic [WRITE_NUM-1:0]  port_use_c;
  logic [RW-1:0]         port_src_c  [WRITE_NUM];
  logic [AW-1:0]         port_addr_c [WRITE_NUM];
  logic [RW-1:0]         last_idx_c;
  logic [RW-1:0]         rr_next_c;
  logic                  scan_en_c;

  // Unpack the flat request buses into per-requester views.
  always_comb begin
    for (int unsigned i = 0; i < REQ_NUM; i++) begin
      req_addr[i] = reqAddr[AW*i +: AW];
      req_data[i] = reqData[DATA_WIDTH*i +: DATA_WIDTH];
    end
  end

  // Grants are also suppressed while reset is asserted.
  assign scan_en_c = !stall && rstN;

  // Round-robin grant scan with same-address suppression and port allocation.
  always_comb begin
    logic [31:0]   scan_sum;
    logic [RW-1:0] idx;
    logic          dup;
    int unsigned   grant_cnt;

    grant_c    = '0;
    port_use_c = '0;
    last_idx_c = '0;
    grant_cnt  = 0;
    scan_sum   = '0;
    idx        = '0;
    dup        = 1'b0;
    for (int unsigned p = 0; p < WRITE_NUM; p++) begin
      port_src_c[p]  = '0;
      port_addr_c[p] = '0;
    end

    for (int unsigned j = 0; j < REQ_NUM; j++) begin
      scan_sum = 32'(rrPtr) + 32'(j);
      if (scan_sum >= 32'(REQ_NUM)) begin
        scan_sum = scan_sum - 32'(REQ_NUM);
      end
      idx = RW'(scan_sum);

      // A requester colliding with an earlier grant waits and takes no port.
      dup = 1'b0;
      for (int unsigned p = 0; p < WRITE_NUM; p++) begin
        if (port_use_c[p] && (port_addr_c[p] == req_addr[idx])) begin
          dup = 1'b1;
        end
      end

      if (scan_en_c && reqValid[idx] && !dup && (grant_cnt < WRITE_NUM)) begin
        for (int unsigned p = 0; p < WRITE_NUM; p++) begin
          if (p == grant_cnt) begin
            port_use_c[p]  = 1'b1;
            port_src_c[p]  = idx;
            port_addr_c[p] = req_addr[idx];
          end
        end
        grant_c[idx] = 1'b1;
        last_idx_c   = idx;
        grant_cnt    = grant_cnt + 1;
      end
    end
  end

  assign reqReady = grant_c;

  // Next scan starts just after the last requester served.
  assign rr_next_c = (last_idx_c == RW'(REQ_NUM - 1)) ? '0 : last_idx_c + RW'(1);

  // Port registers: strobe only real writes; unused ports keep address/data.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      writeEnable <= '0;
      writeAddr   <= '0;
      dataInputs  <= '0;
      rrPtr       <= '0;
    end else begin
      for (int unsigned p = 0; p < WRITE_NUM; p++) begin
        writeEnable[p] <= port_use_c[p] && (port_addr_c[p] != '0);
        if (port_use_c[p]) begin
          writeAddr[AW*p +: AW]                 <= port_addr_c[p];
          dataInputs[DATA_WIDTH*p +: DATA_WIDTH] <= req_data[port_src_c[p]];
        end
      end
      if (|grant_c) begin
        rrPtr <= rr_next_c;
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus a
// randomized run against a queue-based reference model of the grant rules.
module tb_regfile_wb_arbiter;

  localparam int unsigned RN = 8;
  localparam int unsigned WN = 4;
  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;

  logic              clk = 1'b0;
  logic              rstN;
  logic              stall;
  logic [RN-1:0]     reqValid;
  logic [AW*RN-1:0]  reqAddr;
  logic [DW*RN-1:0]  reqData;
  logic [RN-1:0]     reqReady;
  logic [WN-1:0]     writeEnable;
  logic [AW*WN-1:0]  writeAddr;
  logic [DW*WN-1:0]  dataInputs;
  logic [2:0]        rrPtr;

  logic [AW-1:0] tb_addr [RN];
  logic [DW-1:0] tb_data [RN];

  int vecs = 0;
  int errs = 0;

  // reference model state
  int            m_rr;
  logic [WN-1:0] m_we;
  logic [WN-1:0] m_known;
  logic [AW-1:0] m_waddr [WN];
  logic [DW-1:0] m_wdata [WN];
  logic [RN-1:0] m_gmask;
  int            gq[$];

  regfile_wb_arbiter dut (
    .clk         (clk),
    .rstN        (rstN),
    .stall       (stall),
    .reqValid    (reqValid),
    .reqAddr     (reqAddr),
    .reqData     (reqData),
    .reqReady    (reqReady),
    .writeEnable (writeEnable),
    .writeAddr   (writeAddr),
    .dataInputs  (dataInputs),
    .rrPtr       (rrPtr)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < RN; i++) begin
      reqAddr[AW*i +: AW] = tb_addr[i];
      reqData[DW*i +: DW] = tb_data[i];
    end
  end

  task automatic model_reset();
    m_rr    = 0;
    m_we    = '0;
    m_known = '1;
    for (int p = 0; p < WN; p++) begin
      m_waddr[p] = '0;
      m_wdata[p] = '0;
    end
  endtask

  // Walk requesters in round-robin order, collecting grants in a queue.
  task automatic model_scan(input logic [RN-1:0] v, input logic st);
    gq.delete();
    m_gmask = '0;
    if (!st) begin
      for (int j = 0; j < RN; j++) begin
        int  i;
        bit  dup;
        i   = (m_rr + j) % RN;
        dup = 0;
        foreach (gq[q]) if (tb_addr[gq[q]] == tb_addr[i]) dup = 1;
        if (v[i] && !dup && gq.size() < WN) begin
          gq.push_back(i);
          m_gmask[i] = 1'b1;
        end
      end
    end
  endtask

  task automatic model_commit();
    for (int p = 0; p < WN; p++) begin
      if (p < gq.size()) begin
        m_we[p] = (tb_addr[gq[p]] != 0);
        if (tb_addr[gq[p]] != 0) begin
          m_waddr[p] = tb_addr[gq[p]];
          m_wdata[p] = tb_data[gq[p]];
          m_known[p] = 1'b1;
        end else begin
          m_known[p] = 1'b0;
        end
      end else begin
        m_we[p] = 1'b0;
      end
    end
    if (gq.size() > 0) m_rr = (gq[gq.size()-1] + 1) % RN;
  endtask

  task automatic check_outputs(input string tag);
    vecs++;
    if (writeEnable !== m_we) begin
      errs++;
      $display("FAIL %s writeEnable got %b exp %b", tag, writeEnable, m_we);
    end
    vecs++;
    if (rrPtr !== 3'(m_rr)) begin
      errs++;
      $display("FAIL %s rrPtr got %0d exp %0d", tag, rrPtr, m_rr);
    end
    for (int p = 0; p < WN; p++) begin
      if (m_known[p]) begin
        vecs++;
        if (writeAddr[AW*p +: AW] !== m_waddr[p] || dataInputs[DW*p +: DW] !== m_wdata[p]) begin
          errs++;
          $display("FAIL %s port%0d addr/data got %0d/%h exp %0d/%h", tag, p,
                   writeAddr[AW*p +: AW], dataInputs[DW*p +: DW], m_waddr[p], m_wdata[p]);
        end
      end
    end
    for (int p = 0; p < WN; p++) begin
      for (int q = p + 1; q < WN; q++) begin
        if (writeEnable[p] && writeEnable[q] && writeAddr[AW*p +: AW] === writeAddr[AW*q +: AW]) begin
          errs++;
          $display("FAIL %s duplicate write addr %0d on ports %0d,%0d", tag, writeAddr[AW*p +: AW], p, q);
        end
      end
    end
  endtask

  // One clock: drive, check grants, clock, check registered outputs.
  task automatic step(input logic [RN-1:0] v, input logic st, input string tag);
    reqValid = v;
    stall    = st;
    #1;
    model_scan(v, st);
    vecs++;
    if (reqReady !== m_gmask) begin
      errs++;
      $display("FAIL %s reqReady got %h exp %h", tag, reqReady, m_gmask);
    end
    @(posedge clk);
    #1;
    model_commit();
    check_outputs(tag);
  endtask

  task automatic do_reset();
    rstN     = 1'b0;
    stall    = 1'b0;
    reqValid = '1;
    #1;
    model_reset();
    vecs++;
    if (reqReady !== '0) begin
      errs++;
      $display("FAIL reset_ready got %h exp 00", reqReady);
    end
    check_outputs("reset");
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset_held");
    rstN     = 1'b1;
    reqValid = '0;
  endtask

  task automatic set_distinct();
    for (int i = 0; i < RN; i++) begin
      tb_addr[i] = AW'(i + 1);
      tb_data[i] = $urandom;
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < RN; i++) begin
      tb_addr[i] = '0;
      tb_data[i] = '0;
    end
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    tb_addr[0] = 5'd5;
    tb_data[0] = 32'hA5A5_0001;
    step(8'h01, 1'b0, "single");
    vecs++;
    if (writeEnable !== 4'b0001 || writeAddr[4:0] !== 5'd5 ||
        dataInputs[31:0] !== 32'hA5A5_0001 || rrPtr !== 3'd1) begin
      errs++;
      $display("FAIL single_const we=%b addr=%0d data=%h rr=%0d exp 0001/5/a5a50001/1",
               writeEnable, writeAddr[4:0], dataInputs[31:0], rrPtr);
    end
  endtask

  task automatic test_full();
    do_reset();
    set_distinct();
    step(8'hFF, 1'b0, "full_c1");
    vecs++;
    if (rrPtr !== 3'd4 || writeEnable !== 4'b1111 || dataInputs[DW*3 +: DW] !== tb_data[3]) begin
      errs++;
      $display("FAIL full_c1_const rr=%0d we=%b exp 4/1111", rrPtr, writeEnable);
    end
    step(8'hF0, 1'b0, "full_c2");
    vecs++;
    if (rrPtr !== 3'd0 || writeAddr[4:0] !== 5'd5 || dataInputs[31:0] !== tb_data[4]) begin
      errs++;
      $display("FAIL full_c2_const rr=%0d port0 addr=%0d exp 0/5", rrPtr, writeAddr[4:0]);
    end
  endtask

  task automatic test_conflict();
    do_reset();
    set_distinct();
    tb_addr[1] = 5'd9;
    tb_addr[2] = 5'd9;
    step(8'h06, 1'b0, "conflict_c1");
    vecs++;
    if (writeEnable !== 4'b0001 || dataInputs[31:0] !== tb_data[1]) begin
      errs++;
      $display("FAIL conflict_c1_const we=%b data=%h exp 0001/%h", writeEnable, dataInputs[31:0], tb_data[1]);
    end
    step(8'h04, 1'b0, "conflict_c2");
    vecs++;
    if (writeEnable !== 4'b0001 || writeAddr[4:0] !== 5'd9 || dataInputs[31:0] !== tb_data[2]) begin
      errs++;
      $display("FAIL conflict_c2_const we=%b data=%h exp 0001/%h", writeEnable, dataInputs[31:0], tb_data[2]);
    end
  endtask

  task automatic test_zero_addr();
    do_reset();
    tb_addr[0] = 5'd0;
    tb_data[0] = 32'hDEAD_0000;
    step(8'h01, 1'b0, "zero_addr");
    vecs++;
    if (writeEnable !== 4'b0000 || rrPtr !== 3'd1) begin
      errs++;
      $display("FAIL zero_addr_const we=%b rr=%0d exp 0000/1", writeEnable, rrPtr);
    end
  endtask

  task automatic test_stall();
    do_reset();
    set_distinct();
    step(8'h0F, 1'b0, "stall_pre");
    for (int c = 0; c < 3; c++) begin
      step(8'hFF, 1'b1, "stall");
      vecs++;
      if (reqReady !== 8'h00 || writeEnable !== 4'b0000 || rrPtr !== 3'd4) begin
        errs++;
        $display("FAIL stall_const ready=%h we=%b rr=%0d exp 00/0000/4", reqReady, writeEnable, rrPtr);
      end
    end
    step(8'hF0, 1'b0, "stall_resume");
    vecs++;
    if (rrPtr !== 3'd0 || writeEnable !== 4'b1111) begin
      errs++;
      $display("FAIL stall_resume_const rr=%0d we=%b exp 0/1111", rrPtr, writeEnable);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    set_distinct();
    step(8'hFF, 1'b0, "async_pre");
    #2;
    rstN = 1'b0;
    #1;
    vecs++;
    if (writeEnable !== '0 || writeAddr !== '0 || dataInputs !== '0 || rrPtr !== '0 || reqReady !== '0) begin
      errs++;
      $display("FAIL async_reset we=%b addr=%h rr=%0d ready=%h exp all zero",
               writeEnable, writeAddr, rrPtr, reqReady);
    end
    model_reset();
    @(posedge clk);
    #1;
    rstN = 1'b1;
    step(8'h00, 1'b0, "async_post");
  endtask

  task automatic test_random();
    logic [RN-1:0] pend;
    do_reset();
    pend = '0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < RN; i++) begin
        if (!pend[i] && $urandom_range(0, 1) == 1) begin
          pend[i]    = 1'b1;
          tb_addr[i] = AW'($urandom_range(0, 7));
          tb_data[i] = $urandom;
        end
      end
      step(pend, ($urandom_range(0, 7) == 0), "random");
      pend = pend & ~m_gmask;
    end
  endtask

  initial begin
    rstN     = 1'b0;
    stall    = 1'b0;
    reqValid = '0;
    test_reset();
    test_single();
    test_full();
    test_conflict();
    test_zero_addr();
    test_stall();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
